// File: rtl/mem_issue_sched.sv
// ---------------------------------------------------------------------------
// mem_issue_sched
//   In-order memory-op issue queue. Up to two ops are dispatched per cycle
//   into a circular FIFO, and up to two ops issue per cycle from its head to
//   the memory stage. A recall squashes every entry whose active-list index
//   lies in [new_front, old_front) and truncates the queue to the unsquashed
//   prefix.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   enq_valid_i[1:0]        dispatch requests, slot 0 older than slot 1
//   enq_type_i[1:0]         0 = READ, 1 = WRITE
//   enq_rd_i/imm_i/al_idx_i payload stored with each entry
//   enq_ready_o             at least two entries free
//   mem_stall_i             memory stage accepts nothing this cycle
//   if_recall_i             squash request for [new_front_i, old_front_i)
//   iss_*_o[1:0]            issue ports, slot 0 carries the older op
//   count_o                 current occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
`ifndef AL_SIZE
`define AL_SIZE 16
`endif

module mem_issue_sched #(
    parameter int  DEPTH      = 8,
    parameter bit  DUAL_STORE = 1'b1,
    parameter int  AL_SIZE    = `AL_SIZE,
    localparam int AL_W       = $clog2(AL_SIZE),
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [1:0]           enq_valid_i,
    input  logic [1:0]           enq_type_i,
    input  logic [1:0][4:0]      enq_rd_i,
    input  logic [1:0][31:0]     enq_imm_i,
    input  logic [1:0][AL_W-1:0] enq_al_idx_i,
    output logic                 enq_ready_o,
    input  logic                 mem_stall_i,
    input  logic                 if_recall_i,
    input  logic [AL_W-1:0]      new_front_i,
    input  logic [AL_W-1:0]      old_front_i,
    output logic [1:0]           iss_valid_o,
    output logic [1:0]           iss_type_o,
    output logic [1:0][4:0]      iss_rd_o,
    output logic [1:0][31:0]     iss_imm_o,
    output logic [1:0][AL_W-1:0] iss_al_idx_o,
    output logic [CW-1:0]        count_o
);

    localparam logic [AL_W:0] AL_MOD = (AL_W + 1)'(AL_SIZE);

    typedef struct packed {
        logic            is_write;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [AL_W-1:0] al_idx;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    entry_t        head0, head1, wr0, wr1;
    logic          store_ok, enq_ok, run;
    logic [CW-1:0] n_iss, n_enq, surv;

    // (a - b) mod AL_SIZE, valid for any AL_SIZE, not just powers of two.
    function automatic logic [AL_W:0] al_dist(input logic [AL_W-1:0] a,
                                              input logic [AL_W-1:0] b);
        if (a >= b) return {1'b0, a} - {1'b0, b};
        else        return {1'b0, a} + AL_MOD - {1'b0, b};
    endfunction

    assign enq_ready_o = (count_q <= CW'(DEPTH - 2));
    assign enq_ok      = enq_ready_o && !if_recall_i;
    assign count_o     = count_q;

    // Issue: purely combinational from the two head entries.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        head0    = mem_q[head_q];
        head1    = mem_q[head_q + PW'(1)];
        store_ok = DUAL_STORE || !(head0.is_write && head1.is_write);

        iss_valid_o[0] = (count_q >= CW'(1)) && !mem_stall_i && !if_recall_i;
        iss_valid_o[1] = (count_q >= CW'(2)) && !mem_stall_i && !if_recall_i && store_ok;

        iss_type_o   = {head1.is_write, head0.is_write};
        iss_rd_o     = {head1.rd, head0.rd};
        iss_imm_o    = {head1.imm, head0.imm};
        iss_al_idx_o = {head1.al_idx, head0.al_idx};

        n_iss = CW'(iss_valid_o[0]) + CW'(iss_valid_o[1]);
        n_enq = enq_ok ? CW'(enq_valid_i[0]) + CW'(enq_valid_i[1]) : '0;
    end

    // Recall: count the unsquashed run starting at head. The first squashed
    // entry ends the run, so anything younger is dropped with it.
    always_comb begin
        surv = '0;
        run  = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (run && (CW'(k) < count_q) &&
                !(al_dist(mem_q[head_q + PW'(k)].al_idx, new_front_i) <
                  al_dist(old_front_i, new_front_i)))
                surv = surv + CW'(1);
            else
                run = 1'b0;
        end
    end

    // Pointer / occupancy next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (if_recall_i) begin
            tail_d  = head_q + surv[PW-1:0];
            count_d = surv;
        end else begin
            head_d  = head_q + n_iss[PW-1:0];
            tail_d  = tail_q + n_enq[PW-1:0];
            count_d = count_q + n_enq - n_iss;
        end
    end

    // A lone slot-1 request is written at tail as if it were slot 0.
    always_comb begin
        wr0 = enq_valid_i[0] ? {enq_type_i[0], enq_rd_i[0], enq_imm_i[0], enq_al_idx_i[0]}
                             : {enq_type_i[1], enq_rd_i[1], enq_imm_i[1], enq_al_idx_i[1]};
        wr1 = {enq_type_i[1], enq_rd_i[1], enq_imm_i[1], enq_al_idx_i[1]};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the entry array is reset so issue payloads are never X, even when not valid.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq_ok && |enq_valid_i) mem_q[tail_q] <= wr0;
            if (enq_ok && &enq_valid_i) mem_q[tail_q + PW'(1)] <= wr1;
        end
    end

endmodule

// File: tb/tb_mem_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_mem_issue_sched
//   Two instances (DUAL_STORE=1 as "a", DUAL_STORE=0 as "b") share one
//   stimulus stream. A queue-based reference model predicts both every cycle;
//   a table of hand-derived vectors and a few hand sequences cover the
//   fill / drain / recall / wrap / concurrency / single-store corners, then
//   random traffic runs against the model.
// ---------------------------------------------------------------------------
module tb_mem_issue_sched;

    localparam int DEPTH   = 8;
    localparam int AL_SIZE = 16;
    localparam int AL_W    = 4;
    localparam int CW      = 4;

    logic                 clk, reset;
    logic [1:0]           enq_valid, enq_type;
    logic [1:0][4:0]      enq_rd;
    logic [1:0][31:0]     enq_imm;
    logic [1:0][AL_W-1:0] enq_al;
    logic                 mem_stall, if_recall;
    logic [AL_W-1:0]      new_front, old_front;

    logic                 rdy_a, rdy_b;
    logic [1:0]           iv_a, iv_b, ityp_a, ityp_b;
    logic [1:0][4:0]      ird_a, ird_b;
    logic [1:0][31:0]     iimm_a, iimm_b;
    logic [1:0][AL_W-1:0] ial_a, ial_b;
    logic [CW-1:0]        cnt_a, cnt_b;

    mem_issue_sched #(.DEPTH(DEPTH), .DUAL_STORE(1'b1), .AL_SIZE(AL_SIZE)) dut_a (
        .clk_i(clk), .reset_i(reset), .enq_valid_i(enq_valid), .enq_type_i(enq_type),
        .enq_rd_i(enq_rd), .enq_imm_i(enq_imm), .enq_al_idx_i(enq_al), .enq_ready_o(rdy_a),
        .mem_stall_i(mem_stall), .if_recall_i(if_recall), .new_front_i(new_front),
        .old_front_i(old_front), .iss_valid_o(iv_a), .iss_type_o(ityp_a), .iss_rd_o(ird_a),
        .iss_imm_o(iimm_a), .iss_al_idx_o(ial_a), .count_o(cnt_a));

    mem_issue_sched #(.DEPTH(DEPTH), .DUAL_STORE(1'b0), .AL_SIZE(AL_SIZE)) dut_b (
        .clk_i(clk), .reset_i(reset), .enq_valid_i(enq_valid), .enq_type_i(enq_type),
        .enq_rd_i(enq_rd), .enq_imm_i(enq_imm), .enq_al_idx_i(enq_al), .enq_ready_o(rdy_b),
        .mem_stall_i(mem_stall), .if_recall_i(if_recall), .new_front_i(new_front),
        .old_front_i(old_front), .iss_valid_o(iv_b), .iss_type_o(ityp_b), .iss_rd_o(ird_b),
        .iss_imm_o(iimm_b), .iss_al_idx_o(ial_b), .count_o(cnt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         w;
        bit [4:0]   rd;
        bit [31:0]  imm;
        bit [3:0]   al;
    } ent_t;
    typedef ent_t entq_t[$];

    typedef struct {
        bit        rst;
        bit [1:0]  v;
        bit [1:0]  typ;
        bit [3:0]  al0, al1;
        bit        stall, recall;
        bit [3:0]  nf, of;
        bit [4:0]  rd0, rd1;
        bit [31:0] imm0, imm1;
    } stim_t;

    typedef struct {
        stim_t    s;
        bit       chk;
        bit       rdy;
        bit [1:0] iv;
        bit [1:0] iv_b;
        bit [3:0] al0, al1;
        int       cnt;
    } vec_t;

    int    n_checks = 0;
    int    n_err    = 0;
    entq_t qa, qb;
    bit    model_valid = 1'b0;
    stim_t cur;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic ent_t mk_ent(bit w, bit [4:0] rd, bit [31:0] imm, bit [3:0] al);
        ent_t e;
        e.w = w; e.rd = rd; e.imm = imm; e.al = al;
        return e;
    endfunction

    function automatic bit squashed(bit [3:0] al, bit [3:0] nf, bit [3:0] of);
        int d, r;
        d = (int'(al) - int'(nf) + AL_SIZE) % AL_SIZE;
        r = (int'(of) - int'(nf) + AL_SIZE) % AL_SIZE;
        return d < r;
    endfunction

    function automatic int n_issue(entq_t q, bit dual, stim_t s);
        if (s.recall || s.stall || q.size() == 0) return 0;
        if (q.size() == 1) return 1;
        if (!dual && q[0].w && q[1].w) return 1;
        return 2;
    endfunction

    function automatic entq_t model_next(entq_t q, bit dual, stim_t s);
        entq_t r;
        int    n, keep;
        r = q;
        if (s.rst) begin
            r.delete();
            return r;
        end
        if (s.recall) begin
            keep = 0;
            while (keep < r.size() && !squashed(r[keep].al, s.nf, s.of)) keep++;
            while (r.size() > keep) void'(r.pop_back());
            return r;
        end
        n = n_issue(q, dual, s);
        for (int i = 0; i < n; i++) void'(r.pop_front());
        if (q.size() <= DEPTH - 2) begin
            if (s.v[0]) r.push_back(mk_ent(s.typ[0], s.rd0, s.imm0, s.al0));
            if (s.v[1]) r.push_back(mk_ent(s.typ[1], s.rd1, s.imm1, s.al1));
        end
        return r;
    endfunction

    task automatic cmp_one(input string tag, input entq_t q, input bit dual, input stim_t s,
                           input logic rdy, input logic [1:0] iv, input logic [1:0] ityp,
                           input logic [1:0][4:0] ird, input logic [1:0][31:0] iimm,
                           input logic [1:0][3:0] ial, input logic [CW-1:0] cnt);
        int n;
        n = n_issue(q, dual, s);
        check({tag, ".count"}, 64'(cnt), 64'(q.size()));
        check({tag, ".ready"}, 64'(rdy), 64'(q.size() <= DEPTH - 2));
        check({tag, ".iss_valid"}, 64'(iv), 64'((n == 2) ? 3 : n));
        check({tag, ".payload_known"}, 64'($isunknown({ityp, ird, iimm, ial})), 64'(0));
        if (n >= 1)
            check({tag, ".slot0"}, {ityp[0], ird[0], iimm[0], ial[0]},
                  {q[0].w, q[0].rd, q[0].imm, q[0].al});
        if (n == 2)
            check({tag, ".slot1"}, {ityp[1], ird[1], iimm[1], ial[1]},
                  {q[1].w, q[1].rd, q[1].imm, q[1].al});
    endtask

    // ---------------- cycle helpers ----------------
    task automatic drive(input stim_t s);
        cur       = s;
        reset     = s.rst;
        enq_valid = s.v;
        enq_type  = s.typ;
        enq_al    = {s.al1, s.al0};
        enq_rd    = {s.rd1, s.rd0};
        enq_imm   = {s.imm1, s.imm0};
        mem_stall = s.stall;
        if_recall = s.recall;
        new_front = s.nf;
        old_front = s.of;
        #1;
    endtask

    task automatic finish_cycle();
        if (model_valid) begin
            cmp_one("a", qa, 1'b1, cur, rdy_a, iv_a, ityp_a, ird_a, iimm_a, ial_a, cnt_a);
            cmp_one("b", qb, 1'b0, cur, rdy_b, iv_b, ityp_b, ird_b, iimm_b, ial_b, cnt_b);
        end
        @(posedge clk);
        qa = model_next(qa, 1'b1, cur);
        qb = model_next(qb, 1'b0, cur);
        if (cur.rst) model_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.s);
        if (v.chk) begin
            check($sformatf("v%0d.count", idx), 64'(cnt_a), 64'(v.cnt));
            check($sformatf("v%0d.ready", idx), 64'(rdy_a), 64'(v.rdy));
            check($sformatf("v%0d.iss_valid", idx), 64'(iv_a), 64'(v.iv));
            check($sformatf("v%0d.iss_valid_b", idx), 64'(iv_b), 64'(v.iv_b));
            if (v.iv[0]) check($sformatf("v%0d.al0", idx), 64'(ial_a[0]), 64'(v.al0));
            if (v.iv[1]) check($sformatf("v%0d.al1", idx), 64'(ial_a[1]), 64'(v.al1));
        end
        finish_cycle();
    endtask

    function automatic stim_t st(bit rst, bit [1:0] v, bit [1:0] typ, int al0, int al1,
                                 bit stall, bit recall = 1'b0, int nf = 0, int of = 0);
        stim_t s;
        s.rst = rst; s.v = v; s.typ = typ;
        s.al0 = 4'(al0); s.al1 = 4'(al1);
        s.stall = stall; s.recall = recall;
        s.nf = 4'(nf); s.of = 4'(of);
        s.rd0 = 5'(al0 + 1); s.rd1 = 5'(al1 + 1);
        s.imm0 = 32'hC0DE_0000 + 32'(al0); s.imm1 = 32'hC0DE_0000 + 32'(al1);
        return s;
    endfunction

    function automatic vec_t ve(stim_t s, bit chk, bit rdy, bit [1:0] iv, int al0, int al1, int cnt);
        vec_t v;
        v.s = s; v.chk = chk; v.rdy = rdy; v.iv = iv; v.iv_b = iv;
        v.al0 = 4'(al0); v.al1 = 4'(al1); v.cnt = cnt;
        return v;
    endfunction

    vec_t  tbl[$];
    stim_t rs;

    initial begin
        // Expected values are the outputs seen during that cycle, before its edge.
        // reset
        tbl.push_back(ve(st(1, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 0));
        tbl.push_back(ve(st(1, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0, 0));
        // fill to 8 with stall, fifth pair ignored, then drain
        tbl.push_back(ve(st(0, 3, 0, 0, 1, 1), 1, 1, 0, 0, 0, 0));
        tbl.push_back(ve(st(0, 3, 0, 2, 3, 1), 1, 1, 0, 0, 0, 2));
        tbl.push_back(ve(st(0, 3, 0, 4, 5, 1), 1, 1, 0, 0, 0, 4));
        tbl.push_back(ve(st(0, 3, 0, 6, 7, 1), 1, 1, 0, 0, 0, 6));
        tbl.push_back(ve(st(0, 3, 0, 8, 9, 1), 1, 0, 0, 0, 0, 8));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 0, 3, 0, 1, 8));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 2, 3, 6));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 4, 5, 4));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 6, 7, 2));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0));
        // drain order with 5 entries, last one written through a lone slot 1
        tbl.push_back(ve(st(1, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0));
        tbl.push_back(ve(st(0, 3, 0, 0, 1, 1), 1, 1, 0, 0, 0, 0));
        tbl.push_back(ve(st(0, 3, 0, 2, 3, 1), 1, 1, 0, 0, 0, 2));
        tbl.push_back(ve(st(0, 2, 0, 0, 4, 1), 1, 1, 0, 0, 0, 4));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 0, 1, 5));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 2, 3, 3));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 1, 4, 0, 1));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0));
        // recall [5,7) over 3,4,5,6 with an enqueue attempt in the recall cycle
        tbl.push_back(ve(st(0, 3, 0, 3, 4, 1), 1, 1, 0, 0, 0, 0));
        tbl.push_back(ve(st(0, 3, 0, 5, 6, 1), 1, 1, 0, 0, 0, 2));
        tbl.push_back(ve(st(0, 3, 0, 9, 10, 0, 1, 5, 7), 1, 1, 0, 0, 0, 4));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 3, 4, 2));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0));
        // wrapping recall [15,2) over 14,15,0,1 stored across the DEPTH boundary
        tbl.push_back(ve(st(0, 3, 0, 14, 15, 1), 1, 1, 0, 0, 0, 0));
        tbl.push_back(ve(st(0, 3, 0, 0, 1, 1), 1, 1, 0, 0, 0, 2));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0, 1, 15, 2), 1, 1, 0, 0, 0, 4));
        tbl.push_back(ve(st(0, 3, 0, 5, 6, 0), 1, 1, 1, 14, 0, 1));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 5, 6, 2));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0));
        // count 7, enqueue 2 + issue 2 in one cycle: enqueue dropped
        tbl.push_back(ve(st(1, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0, 0));
        tbl.push_back(ve(st(0, 3, 0, 0, 1, 1), 1, 1, 0, 0, 0, 0));
        tbl.push_back(ve(st(0, 3, 0, 2, 3, 1), 1, 1, 0, 0, 0, 2));
        tbl.push_back(ve(st(0, 3, 0, 4, 5, 1), 1, 1, 0, 0, 0, 4));
        tbl.push_back(ve(st(0, 1, 0, 6, 0, 1), 1, 1, 0, 0, 0, 6));
        tbl.push_back(ve(st(0, 3, 0, 7, 8, 0), 1, 0, 3, 0, 1, 7));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 2, 3, 5));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 3, 4, 5, 3));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 1, 6, 0, 1));
        tbl.push_back(ve(st(0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Single-store instance: WRITE,WRITE,READ at head.
        drive(st(1, 0, 0, 0, 0, 1)); finish_cycle();
        drive(st(0, 3, 3, 0, 1, 1)); finish_cycle();
        drive(st(0, 1, 0, 2, 0, 1)); finish_cycle();
        drive(st(0, 0, 0, 0, 0, 0));
        check("ss.c1.iss_valid_b", 64'(iv_b), 64'(2'b01));
        check("ss.c1.al0_b", 64'(ial_b[0]), 64'(0));
        check("ss.c1.iss_valid_a", 64'(iv_a), 64'(2'b11));
        finish_cycle();
        drive(st(0, 0, 0, 0, 0, 0));
        check("ss.c2.iss_valid_b", 64'(iv_b), 64'(2'b11));
        check("ss.c2.types_b", 64'(ityp_b), 64'(2'b01));
        check("ss.c2.al_b", 64'({ial_b[1], ial_b[0]}), 64'({4'd2, 4'd1}));
        finish_cycle();

        // Reset mid-stream with simultaneous recall and enqueue: reset wins.
        drive(st(0, 3, 0, 9, 10, 1)); finish_cycle();
        drive(st(0, 3, 0, 11, 12, 1)); finish_cycle();
        drive(st(1, 3, 0, 13, 14, 0, 1, 0, 8)); finish_cycle();
        drive(st(0, 0, 0, 0, 0, 0));
        check("mid_reset.count", 64'(cnt_a), 64'(0));
        check("mid_reset.iss_valid", 64'(iv_a), 64'(0));
        check("mid_reset.payload_zero", 64'(iimm_a[0]), 64'(0));
        finish_cycle();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            rs.rst    = ($urandom_range(0, 99) == 0);
            rs.v      = 2'($urandom_range(0, 3));
            rs.typ    = 2'($urandom_range(0, 3));
            rs.al0    = 4'($urandom_range(0, 15));
            rs.al1    = 4'($urandom_range(0, 15));
            rs.stall  = ($urandom_range(0, 3) == 0);
            rs.recall = ($urandom_range(0, 11) == 0);
            rs.nf     = 4'($urandom_range(0, 15));
            rs.of     = 4'($urandom_range(0, 15));
            rs.rd0    = 5'($urandom_range(0, 31));
            rs.rd1    = 5'($urandom_range(0, 31));
            rs.imm0   = $urandom;
            rs.imm1   = $urandom;
            drive(rs);
            finish_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
